dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/riscvibe_pkg.sv | 21 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscvibe_pkg.sv
// Shared RISC-V core types and constants: load/store width encodings
// and the data-memory arbiter state/port enumerations.
package riscvibe_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } arb_port_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: the core (m0) has priority, the debug/loader
// port (m1) is protected from starvation and may lock the memory for itself.
module dmem_arbiter
  import riscvibe_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_width,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_width,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic [31:0] mem_rdata,
  output logic        core_stall
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  arb_port_t        rd_port_q, rd_port_d;
  logic             exclusive;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_port_q    <= PORT_M0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_port_q    <= rd_port_d;
    end
  end

  // A LOCKED cycle with m1_lock already dropped arbitrates as if in ARB.
  assign exclusive = (state_q == LOCKED) && m1_lock;

  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (rst_n) begin
      if (exclusive) begin
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        m1_gnt = (starve_cnt_q == LIMIT_CNT);
        m0_gnt = !m1_gnt;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end

      if (!m1_lock) begin
        state_d = ARB;
      end else if (m1_gnt) begin
        state_d = LOCKED;
      end

      if (m1_gnt || !m1_req) begin
        starve_cnt_d = '0;
      end else if (m0_gnt && (starve_cnt_q != LIMIT_CNT)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = F3_B;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_width = m1_width;
      mem_read  = !m1_we;
      mem_write = m1_we;
    end else if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_width = m0_width;
      mem_read  = !m0_we;
      mem_write = m0_we;
    end
  end

  always_comb begin
    rd_valid_d = mem_read;
    rd_port_d  = m1_gnt ? PORT_M1 : PORT_M0;
  end

  // Read data from the previous cycle's grant is routed back to its owner only.
  assign m0_rvalid  = rst_n && rd_valid_q && (rd_port_q == PORT_M0);
  assign m1_rvalid  = rst_n && rd_valid_q && (rd_port_q == PORT_M1);
  assign m0_rdata   = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata   = m1_rvalid ? mem_rdata : '0;
  assign core_stall = m0_req && !m0_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model and a synchronous memory model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
  } stim_t;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_width;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_width;
  logic        mem_read, mem_write, core_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_width;

  logic [31:0] mem_words [256];
  bit          seeded = 1'b0;

  exp_t sb_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bit   locked = 1'b0;
  int   m0_streak = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_width(m0_width), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_width(m1_width), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_width(mem_width), .mem_rdata(mem_rdata),
    .core_stall(core_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-addressed synchronous memory; filled with distinct words at the first edge.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem_words[i] <= 32'(i) * 32'h9E3779B1 + 32'h1234_5677;
      seeded <= 1'b1;
    end else begin
      if (mem_read) mem_rdata <= mem_words[mem_addr[9:2]];
      if (mem_write) mem_words[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    else passed++;
  endtask

  task automatic failNow(input string name);
    total++;
    $display("[TB] FAIL %s cycle %0d", name, cyc);
  endtask

  task automatic applyStimulus(input bit rst_v, input stim_t s0, input stim_t s1, input bit lock,
                               output bit g0, output bit g1);
    stim_t sel;
    @(negedge clk);
    rst_n = rst_v;
    m0_req = s0.req; m0_we = s0.we; m0_addr = s0.addr; m0_wdata = s0.wdata; m0_width = s0.width;
    m1_req = s1.req; m1_we = s1.we; m1_addr = s1.addr; m1_wdata = s1.wdata; m1_width = s1.width;
    m1_lock = lock;
    cyc++;
    if (!rst_v)
      while (sb_q.size() > 0 && sb_q[0].due == cyc) void'(sb_q.pop_front());
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_v) begin
      if (locked && lock) g1 = s1.req;
      else if (s0.req && s1.req) begin
        g1 = (m0_streak >= LIMIT);
        g0 = !g1;
      end else begin
        g0 = s0.req;
        g1 = s1.req;
      end
    end
    #1;
    checkOutput("m0_gnt", m0_gnt, g0);
    checkOutput("m1_gnt", m1_gnt, g1);
    checkOutput("core_stall", core_stall, s0.req && !g0);
    checkOutput("mem_read", mem_read, (g0 && !s0.we) || (g1 && !s1.we));
    checkOutput("mem_write", mem_write, (g0 && s0.we) || (g1 && s1.we));
    if (g0 || g1) begin
      sel = g1 ? s1 : s0;
      checkOutput("mem_addr", mem_addr, sel.addr);
      checkOutput("mem_width", mem_width, sel.width);
      if (sel.we) checkOutput("mem_wdata", mem_wdata, sel.wdata);
      else sb_q.push_back('{due: cyc + 1, port: g1, data: mem_words[sel.addr[9:2]]});
    end
    if (!rst_v) begin
      locked = 1'b0;
      m0_streak = 0;
    end else begin
      if (!lock) locked = 1'b0;
      else if (g1) locked = 1'b1;
      if (!s1.req || g1) m0_streak = 0;
      else if (g0 && m0_streak < LIMIT) m0_streak++;
    end
  endtask

  // Monitor: pops the scoreboard whenever a read response is due or presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!m0_rvalid) checkOutput("m0_rdata_idle", m0_rdata, 32'h0);
      if (!m1_rvalid) checkOutput("m1_rdata_idle", m1_rdata, 32'h0);
      if (m0_rvalid && m1_rvalid) failNow("both_rvalid");
      if (m0_rvalid || m1_rvalid) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
          e = sb_q.pop_front();
          checkOutput("rvalid_port", 32'(m1_rvalid), 32'(e.port));
          checkOutput("rdata", m1_rvalid ? m1_rdata : m0_rdata, e.data);
        end else begin
          failNow("unexpected_rvalid");
        end
      end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        failNow("missing_rvalid");
        void'(sb_q.pop_front());
      end
    end
  end

  function automatic stim_t mk(input bit req, input bit we, input logic [31:0] addr);
    stim_t s;
    s.req = req; s.we = we; s.addr = addr; s.wdata = $urandom(); s.width = 3'b010;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.req = ($urandom_range(0, 99) < 65);
    s.we = $urandom_range(0, 1) == 1;
    s.addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    s.wdata = $urandom();
    s.width = 3'($urandom_range(0, 5));
    return s;
  endfunction

  initial begin
    stim_t idle, p0, p1, rd0, rd1;
    bit g0, g1, lock;
    int lock_left;
    idle = mk(1'b0, 1'b0, 32'h0);

    applyStimulus(1'b0, mk(1'b1, 1'b0, 32'h10), mk(1'b1, 1'b0, 32'h14), 1'b0, g0, g1);
    applyStimulus(1'b0, mk(1'b1, 1'b1, 32'h10), mk(1'b1, 1'b0, 32'h14), 1'b1, g0, g1);
    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);

    applyStimulus(1'b1, mk(1'b1, 1'b0, 32'h10), idle, 1'b0, g0, g1);
    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);

    rd0 = mk(1'b1, 1'b0, 32'h20);
    rd1 = mk(1'b1, 1'b0, 32'h24);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, rd0, rd1, 1'b0, g0, g1);
      checkOutput("starve_pattern", 32'(g1), 32'((i % 5) == 4));
    end
    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);

    applyStimulus(1'b1, idle, mk(1'b1, 1'b1, 32'h30), 1'b1, g0, g1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, rd0, mk(1'b1, 1'b1, 32'h34 + 32'(4 * i)), 1'b1, g0, g1);
    applyStimulus(1'b1, rd0, idle, 1'b0, g0, g1);
    checkOutput("unlock_m0_gnt", 32'(g0), 32'h1);
    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);

    applyStimulus(1'b1, mk(1'b1, 1'b0, 32'h40), idle, 1'b0, g0, g1);
    applyStimulus(1'b1, idle, mk(1'b1, 1'b0, 32'h44), 1'b0, g0, g1);
    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);

    applyStimulus(1'b1, mk(1'b1, 1'b0, 32'h50), idle, 1'b0, g0, g1);
    applyStimulus(1'b0, rd0, rd1, 1'b0, g0, g1);
    applyStimulus(1'b1, rd0, rd1, 1'b0, g0, g1);
    checkOutput("post_reset_m0_first", 32'(g0), 32'h1);

    p0 = rand_stim();
    p1 = rand_stim();
    lock_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (lock_left == 0 && $urandom_range(0, 39) == 0) lock_left = $urandom_range(1, 6);
      lock = (lock_left > 0);
      if (lock_left > 0) lock_left--;
      applyStimulus(($urandom_range(0, 299) != 0), p0, p1, lock, g0, g1);
      if (g0 || !p0.req) p0 = rand_stim();
      if (g1 || !p1.req) p1 = rand_stim();
    end

    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);
    applyStimulus(1'b1, idle, idle, 1'b0, g0, g1);
    @(negedge clk);
    #3;
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
